// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART serializer with runtime format (5..NB_DATA bits, none/even/odd parity, 1/2 stop).
// Define UART_TX_BREAK_EN to add i_break, which holds the idle line low and blocks starts.
module uart_tx_cfg #(
   parameter int NB_DATA    = 8,
   parameter int NB_NDATA   = 4,
   parameter int OVERSAMPLE = 16,
   parameter int NB_TICK    = 4
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic [NB_DATA-1:0]  i_data,
   input  logic                i_tx_start,
   input  logic [NB_NDATA-1:0] i_n_data,
   input  logic                i_parity_en,
   input  logic                i_parity_odd,
   input  logic                i_two_stop,
`ifdef UART_TX_BREAK_EN
   input  logic                i_break,
`endif
   output logic                o_data,
   output logic                o_ready,
   output logic                o_tx_done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state_q;
   logic [NB_TICK-1:0] tick_q;
   logic [NB_NDATA-1:0] bit_q, n_q, n_d;
   logic [NB_DATA-1:0] shift_q, mask_d;
   logic par_en_q, par_q, par_d, two_q, stop_q, brk, bit_end;
`ifdef UART_TX_BREAK_EN
   assign brk = i_break;
`else
   assign brk = 1'b0;
`endif
   // parity is folded at acceptance so bits above n never reach the line
   always_comb begin
      n_d = (i_n_data < NB_NDATA'(5) || i_n_data > NB_NDATA'(NB_DATA)) ? NB_NDATA'(NB_DATA) : i_n_data;
      mask_d = ~({NB_DATA{1'b1}} << n_d);
      par_d = (^(i_data & mask_d)) ^ i_parity_odd;
      bit_end = i_valid && tick_q == NB_TICK'(OVERSAMPLE - 1);
   end
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= IDLE;
         tick_q <= '0;
         bit_q <= '0;
         n_q <= '0;
         shift_q <= '0;
         par_en_q <= 1'b0;
         par_q <= 1'b0;
         two_q <= 1'b0;
         stop_q <= 1'b0;
         o_data <= 1'b1;
         o_ready <= 1'b1;
         o_tx_done <= 1'b0;
      end else begin
         o_tx_done <= 1'b0;
         if (state_q != IDLE && i_valid) tick_q <= bit_end ? '0 : tick_q + 1'b1;
         case (state_q)
            IDLE: if (o_ready && i_tx_start && !brk) begin
               state_q <= START;
               tick_q <= '0;
               bit_q <= '0;
               stop_q <= 1'b0;
               shift_q <= i_data;
               n_q <= n_d;
               par_en_q <= i_parity_en;
               par_q <= par_d;
               two_q <= i_two_stop;
               o_data <= 1'b0;
               o_ready <= 1'b0;
            end else begin
               o_data <= !brk;
               o_ready <= !brk;
            end
            START: if (bit_end) begin
               state_q <= DATA;
               o_data <= shift_q[0];
            end
            DATA: if (bit_end) begin
               shift_q <= shift_q >> 1;
               bit_q <= bit_q + 1'b1;
               if (bit_q == n_q - 1'b1) begin
                  state_q <= par_en_q ? PARITY : STOP;
                  o_data <= par_en_q ? par_q : 1'b1;
               end else o_data <= shift_q[1];
            end
            PARITY: if (bit_end) begin
               state_q <= STOP;
               o_data <= 1'b1;
            end
            STOP: if (bit_end) begin
               if (two_q && !stop_q) stop_q <= 1'b1;
               else begin
                  state_q <= IDLE;
                  o_tx_done <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed frames; a line monitor decodes each frame and checks it against a scoreboard.
module tb_uart_tx_cfg;
   logic clk = 1'b0;
   logic i_reset, i_valid, i_tx_start, i_parity_en, i_parity_odd, i_two_stop;
   logic [7:0] i_data;
   logic [3:0] i_n_data;
   logic o_data, o_ready, o_tx_done;
   int errors = 0, checks = 0;
   int ph = 0, div = 1, hold = 0;
   typedef struct {string bits; int clocks;} exp_t;
   exp_t q[$];

   uart_tx_cfg #(.NB_DATA(8), .NB_NDATA(4), .OVERSAMPLE(16), .NB_TICK(4)) dut (
      .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
      .i_tx_start(i_tx_start), .i_n_data(i_n_data), .i_parity_en(i_parity_en),
      .i_parity_odd(i_parity_odd), .i_two_stop(i_two_stop),
      .o_data(o_data), .o_ready(o_ready), .o_tx_done(o_tx_done));

   always #5 clk = ~clk;

   task automatic check(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ph++;
      if (hold > 0) begin
         i_valid = 1'b0;
         hold--;
      end else i_valid = ((ph - 1) % div == div - 1);
   endtask

   task automatic send(logic [7:0] d, logic [3:0] n, logic pe, logic po, logic two, string bits, int clocks, bit push);
      for (int i = 0; i < 400 && !o_ready; i++) step();
      check("ready_before_send", int'(o_ready), 1);
      i_data = d;
      i_n_data = n;
      i_parity_en = pe;
      i_parity_odd = po;
      i_two_stop = two;
      i_tx_start = 1'b1;
      ph = 0;
      if (push) q.push_back('{bits, clocks});
      step();
      i_tx_start = 1'b0;
      i_data = ~d;
      i_n_data = 4'd2;
      i_parity_en = ~pe;
      i_parity_odd = ~po;
      i_two_stop = ~two;
   endtask

   task automatic wait_done(int limit);
      for (int i = 0; i < limit && !o_tx_done; i++) step();
      check("done_seen", int'(o_tx_done), 1);
   endtask

   // line monitor: bit index follows the oversample tick count seen on i_valid
   bit active = 0, last = 1, prev = 1;
   int cyc, tk, cur;
   string s;
   int glitch;
   always @(negedge clk) begin
      if (i_reset) active = 0;
      else if (o_tx_done) begin
         if (!active || q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done pulse, expected none (active=%0d pending=%0d)", active, q.size());
         end else begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (s != e.bits) begin
               errors++;
               $display("FAIL frame_bits: got %s expected %s", s, e.bits);
            end
            check("frame_clocks", cyc, e.clocks);
            check("frame_glitch", glitch, 0);
         end
         active = 0;
      end else begin
         if (!active && !o_data && prev) begin
            active = 1;
            cyc = 0;
            tk = 0;
            cur = -1;
            s = "";
            glitch = 0;
         end
         if (active) begin
            if (tk / 16 != cur) begin
               cur = tk / 16;
               last = o_data;
               s = {s, o_data ? "1" : "0"};
            end else if (o_data != last) glitch++;
            if (i_valid) tk++;
            cyc++;
         end
      end
      prev = o_data;
   end

   initial begin
      int dn;
      i_reset = 1'b1;
      i_valid = 1'b1;
      i_tx_start = 1'b0;
      i_data = '0;
      i_n_data = 4'd8;
      i_parity_en = 1'b0;
      i_parity_odd = 1'b0;
      i_two_stop = 1'b0;
      step();
      step();
      i_reset = 1'b0;
      check("reset_data", int'(o_data), 1);
      check("reset_ready", int'(o_ready), 1);
      check("reset_done", int'(o_tx_done), 0);
      // 8N1 0x55
      send(8'h55, 4'd8, 0, 0, 0, "0101010101", 160, 1);
      check("ready_low_in_frame", int'(o_ready), 0);
      check("start_bit", int'(o_data), 0);
      wait_done(400);
      step();
      check("ready_after_done", int'(o_ready), 1);
      // 7 bits with parity; bit 7 of 0xBA must not matter
      send(8'h3A, 4'd7, 1, 0, 0, "0010111001", 160, 1);
      wait_done(400);
      send(8'h3A, 4'd7, 1, 1, 0, "0010111011", 160, 1);
      wait_done(400);
      send(8'hBA, 4'd7, 1, 0, 0, "0010111001", 160, 1);
      wait_done(400);
      // minimum width, odd parity
      send(8'h1F, 4'd5, 1, 1, 0, "01111101", 128, 1);
      wait_done(400);
      // 8N2 then back-to-back start on the ready cycle
      send(8'hFF, 4'd8, 0, 0, 1, "01111111111", 176, 1);
      wait_done(400);
      step();
      check("b2b_ready", int'(o_ready), 1);
      send(8'h0F, 4'd8, 0, 0, 0, "0111100001", 160, 1);
      check("b2b_start_next_edge", int'(o_data), 0);
      wait_done(400);
      // i_valid every 4th clock
      div = 4;
      send(8'hC3, 4'd8, 0, 0, 0, "0110000111", 640, 1);
      wait_done(1000);
      div = 1;
      // 100-clock tick stall mid-bit
      send(8'h96, 4'd8, 0, 0, 0, "0011010011", 260, 1);
      for (int i = 0; i < 40; i++) step();
      hold = 100;
      wait_done(600);
      // reset during data bit 3 aborts silently
      send(8'h33, 4'd8, 0, 0, 0, "", 0, 0);
      for (int i = 0; i < 69; i++) step();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      check("abort_data", int'(o_data), 1);
      check("abort_ready", int'(o_ready), 1);
      check("abort_done", int'(o_tx_done), 0);
      dn = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         dn += int'(o_tx_done);
      end
      check("abort_no_done", dn, 0);
      send(8'hA5, 4'd8, 0, 0, 0, "0101001011", 160, 1);
      wait_done(400);
      // start during frame ignored; n=3 latched as 8
      send(8'h5A, 4'd3, 0, 0, 0, "0010110101", 160, 1);
      for (int i = 0; i < 50; i++) step();
      check("busy_ready", int'(o_ready), 0);
      i_data = 8'h00;
      i_tx_start = 1'b1;
      step();
      i_tx_start = 1'b0;
      wait_done(400);
      dn = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         dn += int'(o_tx_done);
      end
      check("single_done", dn, 0);
      check("pending_frames", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Second-generation UART serializer for the TP2 UART path. Generalises the fixed-format transmitter with:
- runtime frame format: 5..NB_DATA data bits, parity none/even/odd, 1 or 2 stop bits
- a parametrised oversampling ratio
- a ready/start handshake and a single-cycle done pulse

It sits between the TX data source (ALU/interface FSM) and the serial pin. It is driven by the shared baud-tick generator through i_valid.

Parameters:
NB_DATA, 8, maximum data bits per frame; width of i_data.
NB_NDATA, 4, width of i_n_data; must hold NB_DATA.
OVERSAMPLE, 16, i_valid ticks per serial bit (>=2).
NB_TICK, 4, tick counter width; 2**NB_TICK >= OVERSAMPLE.

Ports:
i_clock  in  1  system clock; all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_valid  in  1  baud-tick enable; one pulse = one oversample tick.
i_data  in  NB_DATA  word to send, LSB first.
i_tx_start  in  1  start request; accepted only when o_ready=1.
i_n_data  in  NB_NDATA  data bits this frame (5..NB_DATA).
i_parity_en  in  1  1 = append parity bit.
i_parity_odd  in  1  1 = odd parity, 0 = even.
i_two_stop  in  1  1 = two stop bits, 0 = one.
o_data  out  1  serial line, idle high.
o_ready  out  1  high in IDLE; block can accept a frame.
o_tx_done  out  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset values (next edge with i_reset=1, regardless of state, including mid-frame): o_data=1, o_ready=1, o_tx_done=0, state IDLE, all counters 0. Any frame in progress is aborted silently; no done pulse is produced.
- Acceptance: on any clock edge with o_ready=1 and i_tx_start=1; i_valid is not required.
  - Latched at acceptance: i_data, i_n_data, i_parity_en, i_parity_odd, i_two_stop. Inputs are don't-care afterwards.
  - i_n_data < 5 or > NB_DATA is latched as NB_DATA.
- Latency: o_data drops to 0 on the edge after acceptance. o_ready drops on the same edge.
- Bit timing:
  - Tick counter runs 0..OVERSAMPLE-1, advancing only when i_valid=1.
  - A bit ends on the i_valid cycle where count==OVERSAMPLE-1; the counter wraps to 0.
  - Each serial bit lasts exactly OVERSAMPLE i_valid pulses.
  - The counter is cleared on acceptance.
- FSM, with states IDLE, START, DATA, PARITY, STOP:
  - IDLE: o_data=1, o_ready=1. Goes to START on acceptance.
  - START: o_data=0. Goes to DATA at bit end.
  - DATA: o_data = shift_reg[0]; shift right at each bit end. Bit counter 0..n-1. At bit end with count==n-1, goes to PARITY if parity is enabled, else STOP.
  - PARITY: o_data = XOR of the n active data bits (even), inverted if odd. Goes to STOP at bit end.
  - STOP: o_data=1. Lasts 1 or 2 bit periods. At the final bit end: goes to IDLE and o_tx_done=1 for exactly that one clock.
- Back-to-back frames: o_ready=1 on the cycle after the done pulse. A start on that cycle begins a new START immediately; the line stays high only for the stop-bit duration.
- i_tx_start while o_ready=0 is ignored. It is not queued.
- o_data, o_ready and o_tx_done are registered, with no combinational path from inputs.
- Parity covers only the n active bits; bits above n in i_data are ignored.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input i_break (1 bit).
  - While i_break=1 and state is IDLE: o_data=0 and o_ready=0 on the next edge; starts are not accepted.
  - On release, o_data=1 and o_ready=1 on the next edge.
  - i_break during a frame is ignored until the frame completes.
- Undefined: port absent; behaviour as described above.

Test Plan:
- OVERSAMPLE=16, i_valid=1 every cycle, 8N1, i_data=0x55 -> o_data low 16 clocks, then 1,0,1,0,1,0,1,0 each 16 clocks, then high 16 clocks. o_tx_done pulses once, 160 clocks after o_data falls. o_ready=1 on the next clock.
- i_n_data=7, parity even, i_data=0x3A -> data bits 0,1,0,1,1,1,0 then parity 0, then stop. Repeat with odd parity -> parity bit 1. Repeat with i_data=0xBA -> identical waveform (bit 7 ignored).
- i_two_stop=1, 8N2, i_data=0xFF -> stop high for 32 ticks before the done pulse. A second start on the cycle after done -> start bit begins on the next edge.
- i_valid every 4th clock, 8N1 -> each bit 64 clocks; whole frame 640 clocks to done. Holding i_valid=0 for 100 clocks mid-bit stretches that bit by exactly 100 clocks.
- i_reset asserted during data bit 3 -> next edge o_data=1, o_ready=1, o_tx_done stays 0. New start 0xA5 afterwards transmits correctly.
- i_tx_start pulsed with i_data=0x00 during an active frame -> ignored; current frame unchanged, one done pulse only. i_n_data=3 latched -> frame carries 8 data bits.
